// File: rtl/iseq_source_arbiter.sv
// rtl/iseq_source_arbiter.sv - sequence-atomic arbiter between app and maint instruction sources
// Define ISEQ_ARB_STATS_EN to add the app_seq_cnt / maint_seq_cnt / max_starve ports.
`ifndef END_ISEQ
`define END_ISEQ 4'b0000
`endif

module iseq_source_arbiter #(
  parameter int STARVE_LIMIT  = 64,
  parameter int APP_BURST_MAX = 4,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        app_en,
  input  logic [31:0] app_instr,
  output logic        app_ack,
  input  logic        maint_en,
  input  logic [31:0] maint_instr,
  output logic        maint_ack,
  output logic        out_en,
  output logic [31:0] out_instr,
  input  logic        out_ack,
  output logic        grant_app,
  output logic        grant_maint
`ifdef ISEQ_ARB_STATS_EN
  ,
  output logic [15:0]      app_seq_cnt,
  output logic [15:0]      maint_seq_cnt,
  output logic [CNT_W-1:0] max_starve
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APP   = 2'd1,
    MAINT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] STARVE_SAT = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] BURST_SAT  = CNT_W'(APP_BURST_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [3:0]       END_OP     = `END_ISEQ;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic [CNT_W-1:0] app_burst_q, app_burst_d;
  logic             xfer, end_xfer;
  logic             maint_wins, go_maint, go_app;

  assign grant_app   = (state_q == APP);
  assign grant_maint = (state_q == MAINT);

  always_comb begin
    out_en    = 1'b0;
    out_instr = '0;
    if (grant_app) begin
      out_en    = app_en;
      out_instr = app_instr;
    end else if (grant_maint) begin
      out_en    = maint_en;
      out_instr = maint_instr;
    end
  end

  assign app_ack   = out_ack & grant_app;
  assign maint_ack = out_ack & grant_maint;

  assign xfer     = out_en & out_ack;
  assign end_xfer = xfer & (out_instr[31:28] == END_OP);

  // Maint takes the boundary when starved, when app has had its burst, or when app is idle.
  assign maint_wins = maint_en & ((starve_q >= STARVE_SAT) | (app_burst_q >= BURST_SAT) | ~app_en);
  assign go_maint   = (state_q == IDLE) & maint_wins;
  assign go_app     = (state_q == IDLE) & ~maint_wins & app_en;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (go_maint) begin
          state_d = MAINT;
        end else if (go_app) begin
          state_d = APP;
        end
      end
      APP, MAINT: begin
        if (end_xfer) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (go_maint) begin
      starve_d = '0;
    end else if (maint_en && (state_q != MAINT) && (starve_q < STARVE_SAT)) begin
      starve_d = starve_q + CNT_ONE;
    end
  end

  always_comb begin
    app_burst_d = app_burst_q;
    if (go_maint) begin
      app_burst_d = '0;
    end else if (go_app) begin
      if (!maint_en) begin
        app_burst_d = '0;
      end else if (app_burst_q < BURST_SAT) begin
        app_burst_d = app_burst_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      app_burst_q <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      app_burst_q <= app_burst_d;
    end
  end

`ifdef ISEQ_ARB_STATS_EN
  logic [15:0]      app_seq_q, app_seq_d;
  logic [15:0]      maint_seq_q, maint_seq_d;
  logic [CNT_W-1:0] max_starve_q, max_starve_d;

  always_comb begin
    app_seq_d    = app_seq_q;
    maint_seq_d  = maint_seq_q;
    max_starve_d = max_starve_q;
    if (end_xfer && grant_app && (app_seq_q != 16'hFFFF)) begin
      app_seq_d = app_seq_q + 16'd1;
    end
    if (end_xfer && grant_maint && (maint_seq_q != 16'hFFFF)) begin
      maint_seq_d = maint_seq_q + 16'd1;
    end
    if (go_maint && (starve_q > max_starve_q)) begin
      max_starve_d = starve_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      app_seq_q    <= '0;
      maint_seq_q  <= '0;
      max_starve_q <= '0;
    end else begin
      app_seq_q    <= app_seq_d;
      maint_seq_q  <= maint_seq_d;
      max_starve_q <= max_starve_d;
    end
  end

  assign app_seq_cnt   = app_seq_q;
  assign maint_seq_cnt = maint_seq_q;
  assign max_starve    = max_starve_q;
`endif

endmodule

// File: tb/tb_iseq_source_arbiter.sv
// tb/tb_iseq_source_arbiter.sv - scoreboard bench for iseq_source_arbiter
`ifndef END_ISEQ
`define END_ISEQ 4'b0000
`endif

module tb_iseq_source_arbiter;
  logic        clk, rst;
  logic        app_en, maint_en, out_ack;
  logic [31:0] app_instr, maint_instr;
  logic        app_ack, maint_ack, out_en, grant_app, grant_maint;
  logic [31:0] out_instr;

  logic        s_app_en, s_maint_en, s_out_ack;
  logic [31:0] s_app_instr, s_maint_instr;
  logic        s_app_ack, s_maint_ack, s_out_en, s_grant_app, s_grant_maint;
  logic [31:0] s_out_instr;

`ifdef ISEQ_ARB_STATS_EN
  logic [15:0] app_seq_cnt, maint_seq_cnt, s_app_seq_cnt, s_maint_seq_cnt;
  logic [7:0]  max_starve, s_max_starve;
`endif

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] app_q[$], maint_q[$], exp_app[$], exp_maint[$];
  bit          app_pause = 0;

  iseq_source_arbiter #(.STARVE_LIMIT(64), .APP_BURST_MAX(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .app_en(app_en), .app_instr(app_instr), .app_ack(app_ack),
    .maint_en(maint_en), .maint_instr(maint_instr), .maint_ack(maint_ack),
    .out_en(out_en), .out_instr(out_instr), .out_ack(out_ack),
    .grant_app(grant_app), .grant_maint(grant_maint)
`ifdef ISEQ_ARB_STATS_EN
    , .app_seq_cnt(app_seq_cnt), .maint_seq_cnt(maint_seq_cnt), .max_starve(max_starve)
`endif
  );

  iseq_source_arbiter #(.STARVE_LIMIT(5), .APP_BURST_MAX(4), .CNT_W(8)) dut_s (
    .clk(clk), .rst(rst),
    .app_en(s_app_en), .app_instr(s_app_instr), .app_ack(s_app_ack),
    .maint_en(s_maint_en), .maint_instr(s_maint_instr), .maint_ack(s_maint_ack),
    .out_en(s_out_en), .out_instr(s_out_instr), .out_ack(s_out_ack),
    .grant_app(s_grant_app), .grant_maint(s_grant_maint)
`ifdef ISEQ_ARB_STATS_EN
    , .app_seq_cnt(s_app_seq_cnt), .maint_seq_cnt(s_maint_seq_cnt), .max_starve(s_max_starve)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] mk(bit is_end, logic [27:0] id);
    logic [3:0] op;
    op = `END_ISEQ;
    if (!is_end) op = op ^ 4'h8;
    return {op, id};
  endfunction

  task automatic push_seq(bit to_maint, int n, logic [27:0] base);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = mk(i == n - 1, base + 28'(i));
      if (to_maint) begin
        maint_q.push_back(w);
        exp_maint.push_back(w);
      end else begin
        app_q.push_back(w);
        exp_app.push_back(w);
      end
    end
  endtask

  task automatic drive();
    app_en      = !app_pause && (app_q.size() != 0);
    app_instr   = (app_q.size() != 0) ? app_q[0] : 32'h0;
    maint_en    = (maint_q.size() != 0);
    maint_instr = (maint_q.size() != 0) ? maint_q[0] : 32'h0;
  endtask

  task automatic tick();
    logic a, m;
    @(negedge clk);
    a = app_ack & app_en;
    m = maint_ack & maint_en;
    @(posedge clk);
    #1;
    if (a) void'(app_q.pop_front());
    if (m) void'(maint_q.pop_front());
    drive();
    #1;
  endtask

  // Scoreboard: each transferred word is matched against the granted source's expected stream.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst) begin
      n_total++;
      if (grant_app && grant_maint) $display("FAIL both_granted: got 1 1 want not both");
      else n_pass++;
      if (out_en && out_ack) begin
        n_total++;
        if (grant_app) begin
          if (exp_app.size() == 0) $display("FAIL sb_app_extra: got %h want none", out_instr);
          else begin
            e = exp_app.pop_front();
            if (out_instr !== e) $display("FAIL sb_app_word: got %h want %h", out_instr, e);
            else n_pass++;
          end
        end else if (grant_maint) begin
          if (exp_maint.size() == 0) $display("FAIL sb_maint_extra: got %h want none", out_instr);
          else begin
            e = exp_maint.pop_front();
            if (out_instr !== e) $display("FAIL sb_maint_word: got %h want %h", out_instr, e);
            else n_pass++;
          end
        end else $display("FAIL sb_ungranted: out_en=1 with no grant");
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    app_en = 1'b1; app_instr = 32'hDEAD_BEEF; maint_en = 1'b1; maint_instr = 32'hCAFE_F00D;
    out_ack = 1'b1;
    s_app_en = 1'b0; s_app_instr = '0; s_maint_en = 1'b0; s_maint_instr = '0; s_out_ack = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_total++; if (grant_app !== 1'b0) $display("FAIL reset_grant_app: got %b want 0", grant_app); else n_pass++;
    n_total++; if (grant_maint !== 1'b0) $display("FAIL reset_grant_maint: got %b want 0", grant_maint); else n_pass++;
    n_total++; if (out_en !== 1'b0) $display("FAIL reset_out_en: got %b want 0", out_en); else n_pass++;
    n_total++; if (out_instr !== 32'h0) $display("FAIL reset_out_instr: got %h want 0", out_instr); else n_pass++;
    n_total++; if ({app_ack, maint_ack} !== 2'b00) $display("FAIL reset_acks: got %b want 00", {app_ack, maint_ack}); else n_pass++;
    app_en = 1'b0; maint_en = 1'b0; app_instr = '0; maint_instr = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  task automatic test_single_app();
    bit ga[8];
    int acks = 0, macks = 0;
    push_seq(0, 3, 28'h100);
    out_ack = 1'b1;
    drive();
    #1;
    for (int c = 0; c < 8; c++) begin
      ga[c] = grant_app;
      if (app_ack) acks++;
      if (maint_ack) macks++;
      tick();
    end
    n_total++; if (ga[0] !== 1'b0) $display("FAIL single_grant_c0: got %b want 0", ga[0]); else n_pass++;
    n_total++; if (ga[1] !== 1'b1) $display("FAIL single_grant_c1: got %b want 1", ga[1]); else n_pass++;
    n_total++; if (acks != 3) $display("FAIL single_app_acks: got %0d want 3", acks); else n_pass++;
    n_total++; if (ga[4] !== 1'b0) $display("FAIL single_idle_after_end: got %b want 0", ga[4]); else n_pass++;
    n_total++; if (macks != 0) $display("FAIL single_maint_ack: got %0d want 0", macks); else n_pass++;
    n_total++; if (exp_app.size() != 0) $display("FAIL single_sb_left: got %0d want 0", exp_app.size()); else n_pass++;
`ifdef ISEQ_ARB_STATS_EN
    n_total++; if (app_seq_cnt !== 16'd1) $display("FAIL stats_app_seq: got %0d want 1", app_seq_cnt); else n_pass++;
`endif
  endtask

  task automatic test_simultaneous();
    int first_app = -1, first_maint = -1;
    bit ga[12], gm[12];
    push_seq(0, 2, 28'h200);
    push_seq(1, 2, 28'h300);
    drive();
    #1;
    for (int c = 0; c < 12; c++) begin
      ga[c] = grant_app;
      gm[c] = grant_maint;
      if (grant_app && first_app < 0) first_app = c;
      if (grant_maint && first_maint < 0) first_maint = c;
      tick();
    end
    n_total++; if (first_app != 1) $display("FAIL simul_first_app: got %0d want 1", first_app); else n_pass++;
    n_total++; if (first_maint != 4) $display("FAIL simul_first_maint: got %0d want 4", first_maint); else n_pass++;
    n_total++; if ({ga[3], gm[3]} !== 2'b00) $display("FAIL simul_bubble: got %b want 00", {ga[3], gm[3]}); else n_pass++;
    n_total++; if (exp_app.size() + exp_maint.size() != 0) $display("FAIL simul_sb_left: got %0d want 0", exp_app.size() + exp_maint.size()); else n_pass++;
  endtask

  task automatic test_burst();
    int app_seqs = 0;
    bit seen_maint = 0;
    for (int s = 0; s < 6; s++) push_seq(0, 2, 28'h1000 + 28'(s * 16));
    push_seq(1, 2, 28'h2000);
    drive();
    #1;
    for (int c = 0; c < 80 && (app_q.size() + maint_q.size() != 0); c++) begin
      if (grant_maint && !seen_maint) begin
        seen_maint = 1;
        n_total++; if (dut.app_burst_q !== 8'd0) $display("FAIL burst_cleared: got %0d want 0", dut.app_burst_q); else n_pass++;
      end
      if (!seen_maint && app_ack && app_en && app_instr[31:28] == `END_ISEQ) app_seqs++;
      tick();
    end
    n_total++; if (app_seqs != 4) $display("FAIL burst_app_seqs: got %0d want 4", app_seqs); else n_pass++;
    n_total++; if (!seen_maint) $display("FAIL burst_maint_granted: got 0 want 1"); else n_pass++;
    n_total++; if (app_q.size() + maint_q.size() != 0) $display("FAIL burst_drain: got %0d words left want 0", app_q.size() + maint_q.size()); else n_pass++;
  endtask

  task automatic test_starve_limit();
    int k_app = 0, k_m = 0, end_cyc = -1, max_seen = 0;
    bit ga[40], gm[40];
    logic a, m;
    s_out_ack = 1'b1;
    for (int c = 0; c < 40; c++) begin
      s_app_en      = (k_app < 22);
      s_app_instr   = mk((k_app == 19) || (k_app == 21), 28'h500 + 28'(k_app));
      s_maint_en    = (k_m < 1);
      s_maint_instr = mk(1, 28'h5FF);
      #1;
      ga[c] = s_grant_app;
      gm[c] = s_grant_maint;
      if (int'(dut_s.starve_q) > max_seen) max_seen = int'(dut_s.starve_q);
      @(negedge clk);
      a = s_app_ack & s_app_en;
      m = s_maint_ack & s_maint_en;
      if (a && k_app == 19) end_cyc = c;
      @(posedge clk);
      #1;
      if (a) k_app++;
      if (m) k_m++;
    end
    s_out_ack = 1'b0; s_app_en = 1'b0; s_maint_en = 1'b0;
    n_total++; if (max_seen != 5) $display("FAIL starve_sat: got %0d want 5", max_seen); else n_pass++;
    n_total++; if (end_cyc != 20) $display("FAIL starve_app_end: got %0d want 20", end_cyc); else n_pass++;
    n_total++; if (gm[21] !== 1'b0) $display("FAIL starve_bubble: got %b want 0", gm[21]); else n_pass++;
    n_total++; if ({ga[22], gm[22]} !== 2'b01) $display("FAIL starve_forced_maint: got %b want 01", {ga[22], gm[22]}); else n_pass++;
    n_total++; if (k_m != 1 || k_app != 22) $display("FAIL starve_drain: got %0d/%0d want 1/22", k_m, k_app); else n_pass++;
    #1;
  endtask

  task automatic test_pause();
    bit seen_maint = 0;
    push_seq(0, 4, 28'h400);
    push_seq(1, 1, 28'h4FF);
    drive();
    #1;
    for (int c = 0; c < 20; c++) begin
      if (c >= 2 && c <= 4) begin
        n_total++; if (out_en !== 1'b0) $display("FAIL pause_out_en c%0d: got %b want 0", c, out_en); else n_pass++;
        n_total++; if (grant_app !== 1'b1) $display("FAIL pause_grant c%0d: got %b want 1", c, grant_app); else n_pass++;
        n_total++; if (maint_ack !== 1'b0) $display("FAIL pause_maint_ack c%0d: got %b want 0", c, maint_ack); else n_pass++;
      end
      if (grant_maint) seen_maint = 1;
      app_pause = (c + 1 >= 2) && (c + 1 <= 4);
      tick();
    end
    app_pause = 0;
    n_total++; if (exp_app.size() != 0) $display("FAIL pause_resume: got %0d words left want 0", exp_app.size()); else n_pass++;
    n_total++; if (!seen_maint) $display("FAIL pause_maint_after: got 0 want 1"); else n_pass++;
  endtask

  task automatic test_async_reset();
    push_seq(1, 4, 28'h600);
    drive();
    #1;
    tick();
    tick();
    n_total++; if (grant_maint !== 1'b1) $display("FAIL areset_pre_grant: got %b want 1", grant_maint); else n_pass++;
    #3 rst = 1'b1;
    #1;
    n_total++; if (grant_maint !== 1'b0) $display("FAIL areset_grant: got %b want 0", grant_maint); else n_pass++;
    n_total++; if (out_en !== 1'b0) $display("FAIL areset_out_en: got %b want 0", out_en); else n_pass++;
    n_total++; if ({app_ack, maint_ack} !== 2'b00) $display("FAIL areset_acks: got %b want 00", {app_ack, maint_ack}); else n_pass++;
    maint_q.delete();
    exp_maint.delete();
    drive();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_total++; if ({grant_app, grant_maint} !== 2'b00) $display("FAIL areset_idle: got %b want 00", {grant_app, grant_maint}); else n_pass++;
    n_total++; if (dut.starve_q !== 8'd0 || dut.app_burst_q !== 8'd0) $display("FAIL areset_counters: got %0d/%0d want 0/0", dut.starve_q, dut.app_burst_q); else n_pass++;
`ifdef ISEQ_ARB_STATS_EN
    n_total++; if ({app_seq_cnt, maint_seq_cnt, max_starve} !== 40'h0) $display("FAIL areset_stats: got %0d/%0d/%0d want 0/0/0", app_seq_cnt, maint_seq_cnt, max_starve); else n_pass++;
`endif
    push_seq(0, 1, 28'h700);
    drive();
    #1;
    tick();
    n_total++; if (grant_app !== 1'b1 || app_ack !== 1'b1) $display("FAIL areset_one_word: got %b%b want 11", grant_app, app_ack); else n_pass++;
    tick();
    n_total++; if (grant_app !== 1'b0) $display("FAIL areset_one_word_end: got %b want 0", grant_app); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_app();
    test_simultaneous();
    test_burst();
    test_starve_limit();
    test_pause();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/iseq_source_arbiter.md
Name: iseq_source_arbiter

Overview:
Shares the single instruction-receiver input between two instruction-sequence sources: the host application path (app) and the maintenance/refresh generator (maint).
- Grants one source for a whole instruction sequence, up to and including its `END_ISEQ` word, and never interleaves the two.
- Sits between the PCIe/host instruction FIFO plus the maintenance engine upstream and the instruction receiver downstream.
- Applies starvation-bounded priority so refresh sequences are never delayed indefinitely by back-to-back app traffic.

Parameters:
- STARVE_LIMIT, default 64: cycles maint_en may wait ungranted before maint gets forced priority at the next sequence boundary.
- APP_BURST_MAX, default 4: maximum consecutive app sequence grants while maint_en is pending.
- CNT_W, default 8: width of the starvation and burst counters. Must satisfy 2^CNT_W > max(STARVE_LIMIT, APP_BURST_MAX).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- app_en  in  1  app source has a valid instruction.
- app_instr  in  32  app instruction word.
- app_ack  out  1  app word consumed this cycle.
- maint_en  in  1  maint source has a valid instruction.
- maint_instr  in  32  maint instruction word.
- maint_ack  out  1  maint word consumed this cycle.
- out_en  out  1  valid instruction to the receiver.
- out_instr  out  32  instruction word to the receiver.
- out_ack  in  1  receiver consumed out_instr this cycle.
- grant_app  out  1  app currently owns the receiver.
- grant_maint  out  1  maint currently owns the receiver.

Behaviour:
- State register: IDLE, APP, MAINT. Reset value is IDLE. Async reset clears state and all counters immediately.
- Reset values: grant_app=0, grant_maint=0, out_en=0, app_ack=0, maint_ack=0. out_instr=0 whenever not granted.
- grant_app = (state==APP); grant_maint = (state==MAINT). Both are registered.
- Datapath is combinational pass-through from the granted source: out_en = granted source en, out_instr = granted source instr.
- Acks: app_ack = out_ack & grant_app; maint_ack = out_ack & grant_maint. Zero-latency handshake. A word transfers when out_en & out_ack.
- The ungranted source's ack is always 0.
- IDLE arbitration is evaluated each cycle and the state updates at the next edge, giving a 1-cycle bubble between sequences:
  - maint_en & (starve_cnt >= STARVE_LIMIT | app_burst >= APP_BURST_MAX | ~app_en) -> MAINT
  - else app_en -> APP
  - else stay in IDLE.
- Simultaneous app_en and maint_en with no limit reached -> APP.
- APP/MAINT -> IDLE on the cycle the granted source transfers a word with instr[31:28] == `END_ISEQ` (from softmc_define.vh). The END word itself is forwarded and acked.
- While granted, a source dropping en mid-sequence holds the grant (no timeout): out_en=0 and the grant persists.
- out_ack while out_en=0 has no effect.
- starve_cnt: +1 each cycle maint_en=1 and state!=MAINT, saturating at STARVE_LIMIT. Cleared on the IDLE->MAINT transition. Holds when maint_en=0.
- app_burst:
  - On IDLE->APP: +1 if maint_en=1, else cleared to 0.
  - Saturates at APP_BURST_MAX.
  - Cleared on IDLE->MAINT.
- A one-word sequence (first word is `END_ISEQ`): grant lasts exactly one transfer, then returns to IDLE.
- Reset mid-sequence abandons the partial sequence. The downstream receiver is reset by the same rst.

Optional Feature:
ISEQ_ARB_STATS_EN. When defined, three extra output ports are added:
- app_seq_cnt  out  16  completed app sequences.
- maint_seq_cnt  out  16  completed maint sequences.
- max_starve  out  CNT_W  largest starve_cnt value reached before a maint grant.

Counter rules:
- The two sequence counters increment on the `END_ISEQ` transfer of the respective source and saturate at 16'hFFFF.
- All three reset to 0.

When not defined, these ports and their registers are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then app_en=1 with a 3-word sequence (END last) and out_ack=1 -> grant_app rises 1 cycle after app_en; app_ack pulses 3 cycles; returns to IDLE after the END word; maint_ack stays 0.
- app_en and maint_en both asserted in IDLE, limits at 0 -> APP granted first; maint granted after the app END plus the 1-cycle bubble.
- Continuous app sequences of 2 words, maint_en held high, APP_BURST_MAX=4, large STARVE_LIMIT -> exactly 4 app sequences, then MAINT; app_burst reads 0 after the maint grant.
- STARVE_LIMIT=5, app sequence of 20 words with maint_en high -> starve_cnt saturates at 5; MAINT is granted right after the app END regardless of app_burst.
- Granted app drops app_en for 3 cycles mid-sequence while maint_en=1 -> out_en=0 and grant_app held throughout; no maint_ack; sequence resumes.
- Assert rst asynchronously mid-maint-sequence -> grant_maint, out_en and acks drop without waiting for a clock edge; after release, state is IDLE and counters are 0 (stats counters also 0 with ISEQ_ARB_STATS_EN).
